// File: rtl/scalar_flag_cond_unit.sv
// Scalar ALU flag register and branch-condition evaluator.
// Holds N/Z/C/V, resolves 4-bit condition codes for the branch stage over a
// valid/ready handshake, and tracks arithmetic overflow (sticky bit plus a
// saturating event counter).
module scalar_flag_cond_unit #(
  parameter int CNT_W  = 8,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [2:0]       alu_sel,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             flag_we,
  input  logic             br_valid,
  input  logic [3:0]       br_cond,
  output logic             br_ready,
  output logic             res_valid,
  output logic             res_taken,
  input  logic             res_ready,
  input  logic             sticky_clr,
  output logic [3:0]       flags,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count
);

  // WAIT is the one-cycle stall used when bypass is disabled and the
  // request collides with a flag write.
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [3:0]       flags_q, flags_d, flags_eff;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cond_q, cond_d;
  logic             tk_q, tk_d;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             flag_upd, arith_op;

  // Condition code evaluation against a {N,Z,C,V} vector.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c & !z;
      4'd9:    cond_eval = !c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign flag_upd = alu_valid & flag_we;
  assign arith_op = (alu_sel[2:1] == 2'b01);

  // Flags as they will be after this edge; also the bypass source for branches.
  always_comb begin
    flags_eff = flags_q;
    if (flag_upd) begin
      flags_eff[3] = alu_n;
      flags_eff[2] = alu_z;
      if (arith_op) begin
        flags_eff[1] = alu_c;
        flags_eff[0] = alu_v;
      end
    end
    flags_d = flags_eff;
  end

  // Sticky overflow and saturating event counter; clear beats increment.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (sticky_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (flag_upd && arith_op && alu_v) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Branch request FSM: the outcome is snapshotted from the flags seen at
  // acceptance (or right after the stall), so later flag writes cannot alter it.
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    tk_d        = tk_q;
    res_valid_d = res_valid_q;
    res_taken_d = res_taken_q;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (FWD_EN || !flag_upd) begin
            tk_d    = cond_eval(br_cond, flags_eff);
            state_d = EVAL;
          end else begin
            cond_d  = br_cond;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        tk_d    = cond_eval(cond_q, flags_q);
        state_d = EVAL;
      end
      EVAL: begin
        res_taken_d = tk_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flag and accounting registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      flags_q     <= 4'b0000;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      cond_q      <= 4'd0;
      tk_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      cond_q      <= cond_d;
      tk_q        <= tk_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign br_ready  = (state_q == IDLE);
  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign flags     = flags_q;
  assign sticky_v  = sticky_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_scalar_flag_cond_unit.sv
// Bench for scalar_flag_cond_unit: two instances (bypass on / bypass off)
// share stimulus; a reference model queues expected branch outcomes with
// their due edge, and per-instance monitors pop and compare.
module tb_scalar_flag_cond_unit;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_valid = 1'b0, alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic [2:0] alu_sel = 3'd0;
  logic flag_we = 1'b0, br_valid = 1'b0, res_ready = 1'b0, sticky_clr = 1'b0;
  logic [3:0] br_cond = 4'd0;

  logic [1:0] brr, rv, rt, sv;
  logic [3:0] fl [2];
  logic [CW-1:0] oc [2];

  always #5 clk = ~clk;

  scalar_flag_cond_unit #(.CNT_W(CW), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_sel(alu_sel),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flag_we(flag_we), .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(brr[0]), .res_valid(rv[0]), .res_taken(rt[0]),
    .res_ready(res_ready), .sticky_clr(sticky_clr), .flags(fl[0]),
    .sticky_v(sv[0]), .ovf_count(oc[0]));

  scalar_flag_cond_unit #(.CNT_W(CW), .FWD_EN(1'b0)) dut_stall (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_sel(alu_sel),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flag_we(flag_we), .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(brr[1]), .res_valid(rv[1]), .res_taken(rt[1]),
    .res_ready(res_ready), .sticky_clr(sticky_clr), .flags(fl[1]),
    .sticky_v(sv[1]), .ovf_count(oc[1]));

  typedef struct {bit tk; int due;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // reference model state
  bit mn, mz, mc, mv, msticky;
  int mcnt;
  bit busy [2];
  bit mval [2];
  int due [2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0d want=%0d", nm, edge_n, act, exp);
    end
  endtask

  function automatic bit ref_cond(input int cc, input bit n, input bit z,
                                  input bit c, input bit v);
    case (cc)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return c && !z;
      9: return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // One clock: advance the model on the rising edge, check, return at falling edge.
  task automatic cyc();
    bit en, ez, ec, ev, upd, ar, acc, hs;
    int lat;
    exp_t e;
    @(posedge clk);
    edge_n++;
    upd = alu_valid && flag_we;
    ar  = (alu_sel == 3'b010) || (alu_sel == 3'b011);
    en = mn; ez = mz; ec = mc; ev = mv;
    if (upd) begin
      en = alu_n;
      ez = alu_z;
      if (ar) begin
        ec = alu_c;
        ev = alu_v;
      end
    end
    for (int i = 0; i < 2; i++) begin
      acc = br_valid && !busy[i];
      hs  = mval[i] && res_ready;
      if (hs) begin
        mval[i] = 1'b0;
        busy[i] = 1'b0;
      end
      if (acc) begin
        lat = (i == 0 || !upd) ? 1 : 2;
        e.tk  = ref_cond(int'(br_cond), en, ez, ec, ev);
        e.due = edge_n + lat;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        due[i]  = edge_n + lat;
        busy[i] = 1'b1;
      end else if (busy[i] && !mval[i] && edge_n == due[i]) begin
        mval[i] = 1'b1;
      end
    end
    if (sticky_clr) begin
      msticky = 1'b0;
      mcnt = 0;
    end else if (upd && ar && alu_v) begin
      msticky = 1'b1;
      if (mcnt < CMAX) mcnt++;
    end
    mn = en; mz = ez; mc = ec; mv = ev;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("flags[%0d]", i), int'(fl[i]), int'({mn, mz, mc, mv}));
      chk($sformatf("sticky_v[%0d]", i), int'(sv[i]), int'(msticky));
      chk($sformatf("ovf_count[%0d]", i), int'(oc[i]), mcnt);
      chk($sformatf("br_ready[%0d]", i), int'(brr[i]), int'(!busy[i]));
      chk($sformatf("res_valid[%0d]", i), int'(rv[i]), int'(mval[i]));
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit av, input logic [2:0] sel, input bit n, input bit z,
                     input bit c, input bit v, input bit we, input bit bv,
                     input logic [3:0] cc, input bit rr, input bit clr);
    alu_valid = av; alu_sel = sel; alu_n = n; alu_z = z; alu_c = c; alu_v = v;
    flag_we = we; br_valid = bv; br_cond = cc; res_ready = rr; sticky_clr = clr;
    cyc();
  endtask

  task automatic idle(input bit rr);
    drv(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, rr, 1'b0);
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset flags[%0d]", i), int'(fl[i]), 0);
      chk($sformatf("reset sticky_v[%0d]", i), int'(sv[i]), 0);
      chk($sformatf("reset ovf_count[%0d]", i), int'(oc[i]), 0);
      chk($sformatf("reset res_valid[%0d]", i), int'(rv[i]), 0);
      chk($sformatf("reset res_taken[%0d]", i), int'(rt[i]), 0);
      chk($sformatf("reset br_ready[%0d]", i), int'(brr[i]), 1);
      busy[i] = 1'b0;
      mval[i] = 1'b0;
    end
    mn = 0; mz = 0; mc = 0; mv = 0; msticky = 0; mcnt = 0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard monitor for one instance.
  task automatic mon(input int i);
    bit popped = 1'b0;
    bit held = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        popped = 1'b0;
      end else if (rv[i]) begin
        if (!popped) begin
          chk($sformatf("result expected[%0d]", i), int'(qsize(i) > 0), 1);
          if (qsize(i) > 0) begin
            if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("res_taken[%0d]", i), int'(rt[i]), int'(e.tk));
            chk($sformatf("latency[%0d]", i), edge_n, e.due);
          end
          held = rt[i];
          popped = 1'b1;
        end else begin
          chk($sformatf("res_taken stable[%0d]", i), int'(rt[i]), int'(held));
        end
      end else begin
        popped = 1'b0;
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    do_reset();
    idle(1'b1);

    // sub 5-5: Z=1, C=1, V=0; then EQ and NE
    drv(1, 3'b011, 0, 1, 1, 0, 1, 0, 4'd0, 1, 0);
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd0, 1, 0);
    repeat (4) idle(1'b1);
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd1, 1, 0);
    repeat (4) idle(1'b1);

    // add sets C=1 V=1, logic op must keep C/V
    drv(1, 3'b010, 1, 0, 1, 1, 1, 0, 4'd0, 1, 0);
    drv(1, 3'b100, 0, 0, 0, 0, 1, 0, 4'd0, 1, 0);
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd8, 1, 0);
    repeat (4) idle(1'b1);

    // same-cycle flag write with LT request (bypass vs stall)
    drv(1, 3'b011, 1, 0, 0, 0, 1, 1, 4'd11, 1, 0);
    repeat (4) idle(1'b1);

    // overflow saturation, then clear with a simultaneous overflow
    repeat (5) drv(1, 3'b010, 0, 0, 0, 1, 1, 0, 4'd0, 1, 0);
    drv(1, 3'b011, 0, 0, 0, 1, 1, 0, 4'd0, 1, 1);
    idle(1'b1);

    // result held while consumer stalls and flags keep changing
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd4, 0, 0);
    repeat (5) drv(1, 3'b011, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1, 1, 4'd15, 0, 0);
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd15, 1, 0);
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd14, 1, 0);
    repeat (4) idle(1'b1);

    // reset while a result is held
    drv(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'd14, 0, 0);
    repeat (3) idle(1'b0);
    do_reset();
    idle(1'b1);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      drv(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    repeat (6) idle(1'b1);
    chk("drain queue[0]", q0.size(), 0);
    chk("drain queue[1]", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
